// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a data port and a read-only fetch port share one RAM.
// Each access runs IDLE -> ACC -> RESP, and fetch is forced through after STARVE_LIMIT lost arbitrations.
module mem_arbiter #(
    parameter int unsigned MAX_SIZE     = 2048,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [63:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [63:0] d_rdata_o,
    output logic        d_err_o,
    input  logic        f_req_i,
    input  logic [63:0] f_addr_i,
    output logic        f_ack_o,
    output logic [63:0] f_rdata_o,
    output logic        f_err_o,
    output logic [63:0] ram_addr_o,
    output logic [63:0] ram_wdata_o,
    output logic        ram_re_o,
    output logic        ram_we_o,
    input  logic [63:0] ram_rdata_i,
    output logic        busy_o
);

    localparam logic [63:0] LAST_ADDR = 64'(MAX_SIZE) - 64'd8;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             fetch_q;
    logic             we_q;
    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;

    logic             grant_f;
    logic             in_acc;
    logic             addr_ok;
    logic [63:0]      acc_rdata;

    always_comb begin
        grant_f   = f_req_i && (!d_req_i || (starve_cnt == STARVE_MAX));
        in_acc    = (state == ACC);
        addr_ok   = (addr_q <= LAST_ADDR);
        acc_rdata = (!we_q && addr_ok) ? ram_rdata_i : '0;
    end

    // RAM side is decoded from the latched fields; the write strobe also drops
    // with reset so an access aborted in ACC never commits to memory.
    assign ram_addr_o  = in_acc ? addr_q : '0;
    assign ram_wdata_o = (in_acc && we_q) ? wdata_q : '0;
    assign ram_re_o    = in_acc && !we_q && addr_ok;
    assign ram_we_o    = in_acc && we_q && addr_ok && rst_n_i;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            starve_cnt <= '0;
            fetch_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            d_ack_o    <= 1'b0;
            d_rdata_o  <= '0;
            d_err_o    <= 1'b0;
            f_ack_o    <= 1'b0;
            f_rdata_o  <= '0;
            f_err_o    <= 1'b0;
        end else begin
            d_ack_o   <= 1'b0;
            d_rdata_o <= '0;
            d_err_o   <= 1'b0;
            f_ack_o   <= 1'b0;
            f_rdata_o <= '0;
            f_err_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (f_req_i && !grant_f) begin
                        starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt
                                                                 : starve_cnt + 1'b1;
                    end else begin
                        starve_cnt <= '0;
                    end
                    if (d_req_i || f_req_i) begin
                        fetch_q <= grant_f;
                        we_q    <= !grant_f && d_we_i;
                        addr_q  <= grant_f ? f_addr_i : d_addr_i;
                        wdata_q <= grant_f ? '0 : d_wdata_i;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    if (fetch_q) begin
                        f_ack_o   <= 1'b1;
                        f_rdata_o <= acc_rdata;
                        f_err_o   <= !addr_ok;
                    end else begin
                        d_ack_o   <= 1'b1;
                        d_rdata_o <= acc_rdata;
                        d_err_o   <= !addr_ok;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
